// File: rtl/uart_tx_frame_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_engine
//
// Parametrised UART transmitter sitting between the APB register block and
// the TXD pad. Frame = start bit, DATA_W data bits (LSB first), optional
// parity bit (even/odd), one or two stop bits. A one-entry holding register
// behind a valid/ready handshake lets consecutive frames leave with no idle
// gap. Line configuration is captured when a frame is loaded, so register
// writes during a frame only affect the next one.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tx_data      word to transmit (sampled only on acceptance)
//   tx_valid     tx_data is valid
//   tx_ready     holding register empty; accepted when tx_valid && tx_ready
//   cfg_div      clocks per bit minus 1 (0 is treated as 1)
//   cfg_par_en   append a parity bit
//   cfg_par_odd  1 = odd parity, 0 = even parity
//   cfg_stop2    1 = two stop bits
//   txd          serial line, idle high (registered)
//   busy         a frame is being shifted out
//   frame_done   one-cycle pulse during the last clock of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_frame_engine #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int IDX_W = $clog2(DATA_W + 1);

  logic [2:0]        state_reg, state_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic              hold_full_reg, hold_full_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              stop_idx_reg, stop_idx_next;
  logic [DIV_W-1:0]  cnt_reg, cnt_next;
  logic [DIV_W-1:0]  div_l_reg, div_l_next;
  logic              par_en_reg, par_en_next;
  logic              stop2_reg, stop2_next;
  logic              parity_reg, parity_next;
  logic              txd_reg, txd_next;
  logic              frame_done_reg, frame_done_next;

  logic tick;
  logic frame_end;
  logic load;
  logic accept;

  assign tick      = (state_reg != ST_IDLE) && (cnt_reg == div_l_reg);
  assign frame_end = (state_reg == ST_STOP) && tick && (stop_idx_reg == stop2_reg);
  // Loading at frame_end chains frames back to back with no idle cycle.
  assign load      = hold_full_reg && ((state_reg == ST_IDLE) || frame_end);
  assign accept    = tx_valid && !hold_full_reg;

  always_comb begin
    state_next      = state_reg;
    hold_next       = hold_reg;
    hold_full_next  = hold_full_reg;
    shift_next      = shift_reg;
    idx_next        = idx_reg;
    stop_idx_next   = stop_idx_reg;
    cnt_next        = cnt_reg;
    div_l_next      = div_l_reg;
    par_en_next     = par_en_reg;
    stop2_next      = stop2_reg;
    parity_next     = parity_reg;
    txd_next        = 1'b1;
    frame_done_next = 1'b0;

    // load and accept are mutually exclusive: one needs hold full, the other empty.
    if (accept) begin
      hold_next      = tx_data;
      hold_full_next = 1'b1;
    end else if (load) begin
      hold_full_next = 1'b0;
    end

    if (state_reg != ST_IDLE) begin
      cnt_next = tick ? '0 : cnt_reg + DIV_W'(1);
    end

    if (load) begin
      state_next    = ST_START;
      shift_next    = hold_reg;
      idx_next      = '0;
      stop_idx_next = 1'b0;
      cnt_next      = '0;
      div_l_next    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      par_en_next   = cfg_par_en;
      stop2_next    = cfg_stop2;
      parity_next   = (^hold_reg) ^ cfg_par_odd;
    end else if (tick) begin
      case (state_reg)
        ST_START: begin
          state_next = ST_DATA;
          idx_next   = '0;
        end
        ST_DATA: begin
          shift_next = shift_reg >> 1;
          if (idx_reg == IDX_W'(DATA_W - 1)) begin
            state_next    = par_en_reg ? ST_PARITY : ST_STOP;
            stop_idx_next = 1'b0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
        ST_PARITY: begin
          state_next    = ST_STOP;
          stop_idx_next = 1'b0;
        end
        ST_STOP: begin
          if (stop_idx_reg == stop2_reg) begin
            state_next = ST_IDLE;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Outputs are computed from next-state values so the pad sees a clean
    // flop output that changes on the same edge as the state.
    case (state_next)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = shift_next[0];
      ST_PARITY: txd_next = parity_next;
      default:   txd_next = 1'b1;
    endcase

    frame_done_next = (state_next == ST_STOP) && (stop_idx_next == stop2_next) &&
                      (cnt_next == div_l_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      hold_reg       <= '0;
      hold_full_reg  <= 1'b0;
      shift_reg      <= '0;
      idx_reg        <= '0;
      stop_idx_reg   <= 1'b0;
      cnt_reg        <= '0;
      div_l_reg      <= DIV_W'(1);
      par_en_reg     <= 1'b0;
      stop2_reg      <= 1'b0;
      parity_reg     <= 1'b0;
      txd_reg        <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      hold_full_reg  <= hold_full_next;
      shift_reg      <= shift_next;
      idx_reg        <= idx_next;
      stop_idx_reg   <= stop_idx_next;
      cnt_reg        <= cnt_next;
      div_l_reg      <= div_l_next;
      par_en_reg     <= par_en_next;
      stop2_reg      <= stop2_next;
      parity_reg     <= parity_next;
      txd_reg        <= txd_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign tx_ready   = !hold_full_reg;
  assign txd        = txd_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_engine
//
// Scoreboard bench. The stimulus side pushes each accepted word into sb_q;
// the monitor detects start bits on txd, pops the word, builds the expected
// frame from the line configuration present at the load edge, and checks
// every clock of the frame (txd, busy, frame_done). A second instance with
// DATA_W=5 covers the narrow-word build.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] cfg_div = 16'd3;
  logic        cfg_par_en = 1'b0;
  logic        cfg_par_odd = 1'b0;
  logic        cfg_stop2 = 1'b0;
  logic        txd, busy, frame_done;

  logic [4:0]  d5_data = '0;
  logic        d5_valid = 1'b0;
  logic        d5_ready, d5_txd, d5_busy, d5_frame_done;
  logic [15:0] d5_div = 16'd0;
  logic        d5_par_en = 1'b0, d5_par_odd = 1'b0, d5_stop2 = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame_engine #(.DATA_W(8), .DIV_W(16)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_div(cfg_div), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
    .cfg_stop2(cfg_stop2), .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  uart_tx_frame_engine #(.DATA_W(5), .DIV_W(16)) u_dut5 (
    .clk(clk), .rst(rst), .tx_data(d5_data), .tx_valid(d5_valid), .tx_ready(d5_ready),
    .cfg_div(d5_div), .cfg_par_en(d5_par_en), .cfg_par_odd(d5_par_odd),
    .cfg_stop2(d5_stop2), .txd(d5_txd), .busy(d5_busy), .frame_done(d5_frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference frame: start 0, data LSB first, optional parity, 1 or 2 stop 1s.
  function automatic void build_frame(input logic [8:0] d, input int w, input logic par_en,
                                      input logic odd, input logic stop2,
                                      output logic [15:0] bits, output int n);
    logic p;
    int   k;
    bits    = '1;
    bits[0] = 1'b0;
    k       = 1;
    p       = odd;
    for (int i = 0; i < w; i++) begin
      bits[k] = d[i];
      p       = p ^ d[i];
      k       = k + 1;
    end
    if (par_en) begin
      bits[k] = p;
      k       = k + 1;
    end
    bits[k] = 1'b1;
    k       = k + 1;
    if (stop2) k = k + 1;
    n = k;
  endfunction

  // Configuration as seen by the DUT at the most recent rising edge.
  logic [15:0] snap_div;
  logic        snap_par_en, snap_par_odd, snap_stop2;
  always @(posedge clk) begin
    snap_div     <= cfg_div;
    snap_par_en  <= cfg_par_en;
    snap_par_odd <= cfg_par_odd;
    snap_stop2   <= cfg_stop2;
  end

  // ---------------- monitor ----------------
  bit          in_frame = 1'b0;
  logic [15:0] exp_bits;
  logic [15:0] obs_bits;
  logic [7:0]  cur_word;
  int          nbits, bitlen, cyc, ferr;
  int          idle_cnt = 0, gap_last = -1, idle_err = 0;
  int          last_len = 0, last_bitlen = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        idle_cnt = 0;
        continue;
      end
      if (!in_frame) begin
        if (txd === 1'b0) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: txd low with no queued word, required idle");
          end else begin
            cur_word = sb_q.pop_front();
            build_frame({1'b0, cur_word}, 8, snap_par_en, snap_par_odd, snap_stop2, exp_bits, nbits);
            bitlen   = ((snap_div == 16'd0) ? 1 : int'(snap_div)) + 1;
            in_frame = 1'b1;
            cyc      = 0;
            ferr     = 0;
            obs_bits = '1;
            gap_last = idle_cnt;
            idle_cnt = 0;
          end
        end else begin
          idle_cnt++;
          if (busy !== 1'b0 || frame_done !== 1'b0) idle_err++;
        end
      end
      if (in_frame) begin
        if (cyc % bitlen == 0) obs_bits[cyc / bitlen] = txd;
        if (txd !== exp_bits[cyc / bitlen]) ferr++;
        if (busy !== 1'b1) ferr++;
        if (frame_done !== ((cyc == nbits * bitlen - 1) ? 1'b1 : 1'b0)) ferr++;
        cyc++;
        if (cyc == nbits * bitlen) begin
          n_checks++;
          last_len    = cyc;
          last_bitlen = bitlen;
          if (ferr == 0) begin
            n_pass++;
            $display("frame data=%02h bits=%0d clk/bit=%0d gap=%0d ok", cur_word, nbits, bitlen, gap_last);
          end else begin
            $display("FAIL frame data=%02h: %0d cycle errors, required 0 (obs=%04h exp=%04h)",
                     cur_word, ferr, obs_bits, exp_bits);
          end
          in_frame = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Leaves tx_valid high on return (at the negedge after acceptance).
  task automatic send(input logic [7:0] d);
    int t;
    tx_data  = d;
    tx_valid = 1'b1;
    t = 0;
    while (tx_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      check("send_timeout", 32'(t), 32'd0);
    end else begin
      @(posedge clk);
      sb_q.push_back(d);
      @(negedge clk);
    end
  endtask

  task automatic drop_valid();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || in_frame || busy !== 1'b0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("idle_timeout", 32'(t), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [15:0] b5;
    logic [13:0] obs14, exp14;
    int          n5, fd_cnt, fd_at;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 0xA5, div 3, no parity, 1 stop
    cfg_div = 16'd3; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    send(8'hA5);
    check("ready_drop", tx_ready, 1'b0);
    check("txd_before_load", txd, 1'b1);
    drop_valid();
    @(negedge clk);
    check("start_latency", txd, 1'b0);
    check("ready_after_load", tx_ready, 1'b1);
    wait_idle();
    check("t1_bits", obs_bits[9:0], 10'h34A);
    check("t1_len", 32'(last_len), 32'd40);
    check("t1_busy_after", busy, 1'b0);

    // 2: parity even / odd on 0xA5
    cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
    send(8'hA5); drop_valid(); wait_idle();
    check("t2_even_par", obs_bits[9], 1'b0);
    check("t2_len", 32'(last_len), 32'd44);
    cfg_par_odd = 1'b1;
    send(8'hA5); drop_valid(); wait_idle();
    check("t2_odd_par", obs_bits[9], 1'b1);

    // 3: back-to-back 0x00 then 0xFF, two stop bits, div 1
    cfg_par_en = 1'b0; cfg_stop2 = 1'b1; cfg_div = 16'd1;
    send(8'h00);
    send(8'hFF);
    repeat (3) @(negedge clk);
    check("t3_ready_held", tx_ready, 1'b0);
    drop_valid();
    wait_idle();
    check("t3_gap", 32'(gap_last), 32'd0);
    check("t3_ready_free", tx_ready, 1'b1);

    // 4: change divisor mid-frame; the queued frame picks it up
    cfg_stop2 = 1'b0; cfg_div = 16'd3;
    send(8'h3C);
    send(8'hC3);
    repeat (16) @(negedge clk);
    cfg_div = 16'd7;
    drop_valid();
    wait_idle();
    check("t4_next_bitlen", 32'(last_bitlen), 32'd8);

    // 5: async reset during data bit 5 with a word held
    cfg_div = 16'd3;
    send(8'h5A);
    send(8'h99);
    drop_valid();
    repeat (24) @(negedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    check("t5_txd_async", txd, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", tx_ready, 1'b1);
    check("t5_done", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("t5_no_resend", busy, 1'b0);

    // 6a: cfg_div 0 behaves as 1 (monitor expects 2 clocks per bit)
    cfg_div = 16'd0; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    send(8'h6E); drop_valid(); wait_idle();
    check("t6_div0_bitlen", 32'(last_bitlen), 32'd2);

    // Randomized frames with random configuration and gaps.
    for (int i = 0; i < 30; i++) begin
      cfg_div     = 16'($urandom_range(0, 4));
      cfg_par_en  = 1'($urandom);
      cfg_par_odd = 1'($urandom);
      cfg_stop2   = 1'($urandom);
      send(8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        drop_valid();
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
    end
    drop_valid();
    wait_idle();

    // 6b: DATA_W=5 build, 0x15, div 0 -> 7-bit frame, 2 clocks per bit
    build_frame(9'h015, 5, 1'b0, 1'b0, 1'b0, b5, n5);
    for (int c = 0; c < 14; c++) exp14[c] = b5[c / 2];
    d5_data = 5'h15; d5_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d5_valid = 1'b0; d5_data = 5'h0A;
    fd_cnt = 0; fd_at = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      obs14[c] = d5_txd;
      if (d5_frame_done === 1'b1) begin
        fd_cnt++;
        fd_at = c;
      end
    end
    $display("w5 frame data=15 bits=%0d obs=%04h", n5, obs14);
    check("w5_bits", obs14, exp14);
    check("w5_done_count", 32'(fd_cnt), 32'd1);
    check("w5_done_pos", 32'(fd_at), 32'd13);
    @(negedge clk);
    check("w5_busy_after", d5_busy, 1'b0);

    check("idle_quiet", 32'(idle_err), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
